// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: operand forward selects, load-use stalls, branch flush, dmem-busy freeze.
// Define HAZARD_PERF_EN to add the saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
    parameter int REG_W    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_use,
    input  logic             id_rt_use,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_rs_use,
    input  logic             ex_rt_use,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_wr_reg,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [REG_W-1:0] mem_wr_reg,
    input  logic             wb_wr_en,
    input  logic [REG_W-1:0] wb_wr_reg,
    input  logic             dmem_busy,
    input  logic             br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       id_fwd_rs,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             stall_all,
    output logic [1:0]       hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hzState_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    hzState_t   stateReg, stateNext, effState;
    logic [2:0] cntReg, cntNext;

    logic [REG_W-1:0] exSrc    [2];
    logic             exSrcUse [2];
    logic [1:0]       exSel    [2];
    logic [1:0]       idSel;
    logic             luHit;
    logic             rawStallIf, rawStallId, rawBubbleEx, rawFlushId, rawStallAll;

    assign exSrc[0]    = ex_rs;
    assign exSrc[1]    = ex_rt;
    assign exSrcUse[0] = ex_rs_use;
    assign exSrcUse[1] = ex_rt_use;

    // MEM/WB forwarding for both EX operands; a MEM load has no ALU result yet.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_exFwd
            assign exSel[gi] = !exSrcUse[gi]                                      ? 2'b00 :
                               (mem_wr_en && !mem_is_load && mem_wr_reg == exSrc[gi]) ? 2'b01 :
                               (wb_wr_en && wb_wr_reg == exSrc[gi])                ? 2'b10 :
                                                                                     2'b00;
        end
    endgenerate

    assign idSel = !id_rs_use                                         ? 2'b00 :
                   (ex_wr_en && !ex_is_load && ex_wr_reg == id_rs)    ? 2'b01 :
                   (mem_wr_en && mem_wr_reg == id_rs)                 ? 2'b10 :
                                                                        2'b00;

    assign luHit = ex_wr_en && ex_is_load &&
                   ((id_rs_use && id_rs == ex_wr_reg) || (id_rt_use && id_rt == ex_wr_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= RUN;
            cntReg   <= 3'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        // The cycle dmem_busy drops already behaves as the state being resumed,
        // so the freeze costs exactly the busy cycles and no extra dead cycle.
        effState = stateReg;
        if (stateReg == MEM_WAIT && !dmem_busy)
            effState = (cntReg != 3'd0) ? LU_STALL : RUN;

        stateNext   = effState;
        cntNext     = cntReg;
        rawStallIf  = 1'b0;
        rawStallId  = 1'b0;
        rawBubbleEx = 1'b0;
        rawFlushId  = 1'b0;
        rawStallAll = 1'b0;

        case (effState)
            RUN: begin
                if (dmem_busy) begin
                    rawStallAll = 1'b1;
                    stateNext   = MEM_WAIT;
                end else if (br_taken) begin
                    rawFlushId  = 1'b1;
                    rawBubbleEx = 1'b1;
                    stateNext   = RUN;
                end else if (luHit) begin
                    rawStallIf  = 1'b1;
                    rawStallId  = 1'b1;
                    rawBubbleEx = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cntNext   = LU_INIT;
                        stateNext = LU_STALL;
                    end else begin
                        stateNext = RUN;
                    end
                end else begin
                    stateNext = RUN;
                end
            end
            LU_STALL: begin
                if (dmem_busy) begin
                    rawStallAll = 1'b1;
                    stateNext   = MEM_WAIT;
                end else begin
                    rawStallIf  = 1'b1;
                    rawStallId  = 1'b1;
                    rawBubbleEx = 1'b1;
                    if (cntReg <= 3'd1) begin
                        cntNext   = 3'd0;
                        stateNext = RUN;
                    end else begin
                        cntNext   = cntReg - 3'd1;
                        stateNext = LU_STALL;
                    end
                end
            end
            MEM_WAIT: begin
                rawStallAll = 1'b1;
                stateNext   = MEM_WAIT;
            end
            default: begin
                cntNext   = 3'd0;
                stateNext = RUN;
            end
        endcase
    end

    // Outputs are forced low the moment rst_n falls, including the combinational selects.
    assign fwd_a     = exSel[0] & {2{rst_n}};
    assign fwd_b     = exSel[1] & {2{rst_n}};
    assign id_fwd_rs = idSel & {2{rst_n}};
    assign stall_if  = rawStallIf & rst_n;
    assign stall_id  = rawStallId & rst_n;
    assign bubble_ex = rawBubbleEx & rst_n;
    assign flush_id  = rawFlushId & rst_n;
    assign stall_all = rawStallAll & rst_n;
    assign hz_state  = stateReg & {2{rst_n}};

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCntReg, flushCntReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
        end else begin
            if ((rawStallIf || rawStallAll) && stallCntReg != {CNT_W{1'b1}})
                stallCntReg <= stallCntReg + 1'b1;
            if (rawFlushId && flushCntReg != {CNT_W{1'b1}})
                flushCntReg <= flushCntReg + 1'b1;
        end
    end

    assign stall_cnt = stallCntReg;
    assign flush_cnt = flushCntReg;
`endif

endmodule
